ps2_key_encoder: RTL and testbench
==================================

# ps2_key_encoder

Converts a raw PS/2 keyboard line pair into the 11-bit `ps2_key` event word consumed by the arcade top level's key-decode logic. Layout: bit 10 is a toggle flipped once per event, bit 9 is pressed, bit 8 is extended, bits 7:0 are the scan code. The block runs in the `clk_sys` domain. It deserializes PS/2 frames, checks framing and parity, and folds the E0/F0/E1 prefix bytes into single key events.

## Interface
Parameters:
- `FILT_LEN`, default 4: consecutive identical synchronized `ps2_clk` samples required to change the filtered clock level.
- `TIMEOUT`, default 50000: `clk_sys` cycles without a filtered falling edge before a partial frame is aborted.

Ports:
- `clk_sys`, in, 1: system clock. It is the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data, asynchronous.
- `ps2_key`, out, 11: event word `{toggle, pressed, extended, code[7:0]}`.
- `byte_valid`, out, 1: one-cycle pulse for each frame received without error.
- `byte_err`, out, 1: one-cycle pulse on a framing error, parity error or timeout abort.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through 2-flop synchronizers.
- **Clock filter:**
  - The filtered clock resets high.
  - It goes low on the cycle the FILT_LEN-th consecutive low synchronized sample arrives, and returns high symmetrically.
  - A high-to-low transition of the filtered clock is a bit event. The synchronized `ps2_data` is sampled in that same cycle.
- **Frame format:** 11 bits, in order: start (0), 8 data bits LSB first, odd parity, stop (1). A bit counter runs 0..10.
- **Frame check on bit 10:**
  - Valid when start==0, XOR(data, parity)==1 and stop==1. A valid frame pulses `byte_valid` and passes the byte to the decoder.
  - Otherwise `byte_err` pulses and the byte is discarded.
  - In both cases the bit counter returns to 0.
- **Timeout:**
  - The counter clears on every bit event and otherwise increments, saturating at TIMEOUT.
  - If the counter reaches TIMEOUT while the bit counter is nonzero, `byte_err` pulses and the bit counter clears.
  - An idle line with the bit counter at 0 never errors.
- **Decoder FSM** (states IDLE, EXT, BRK, EXT_BRK, SKIP):
  - E0: IDLE→EXT, BRK→EXT_BRK.
  - F0: IDLE→BRK, EXT→EXT_BRK.
  - E1: from any non-SKIP state → SKIP with the skip counter set to 7.
  - SKIP: each byte decrements the skip counter. At 0 the FSM returns to IDLE. No emission.
  - Any other byte emits an event and the FSM returns to IDLE:
    - `ps2_key[10]` toggles.
    - `[9]` = not in BRK/EXT_BRK.
    - `[8]` = in EXT/EXT_BRK.
    - `[7:0]` = byte.
  - In IDLE only, controller responses 00, AA, EE, FA, FC, FD, FE and FF are dropped with no state change.
  - Redundant prefixes keep state: E0 in EXT or EXT_BRK, F0 in BRK or EXT_BRK.
- **Error recovery:** `byte_err` forces the FSM to IDLE and clears the skip counter.
- **Reset:** on the next edge, all outputs go to 0 (`ps2_key`=11'h000), the FSM goes to IDLE, the filter goes high, and the bit, timeout and skip counters clear. Reset in the middle of a frame discards the partial frame.

## Timing
- Filtered falling edge latency: 2 + FILT_LEN cycles after the raw `ps2_clk` falls. Pulses shorter than FILT_LEN cycles are ignored.
- Stop bit sampled in cycle T: `byte_valid`/`byte_err` are high in cycle T+1 only. `ps2_key` takes its new value in cycle T+1 and holds until the next event.
- `ps2_key[9:0]` and the toggle change in the same cycle, so a consumer's edge detect on bit 10 always sees consistent data.
- At most one event is emitted per received byte. Prefix bytes never toggle bit 10.
- `byte_valid` and `byte_err` are never high in the same cycle.

## Test plan
- **Press:** reset, then frame 0x1C → `byte_valid` pulse, `ps2_key`=11'h61C; bit 10 toggled exactly once.
- **Release:** F0, 1C → only the second byte toggles; `ps2_key`=11'h01C; two `byte_valid` pulses.
- **Extended keys:** E0 75 from toggle 0 → 11'h775. Then E0 F0 75 → 11'h175.
- **Parity error and glitch:**
  - Frame 0x1C sent with even parity → `byte_err` pulse, `ps2_key` unchanged.
  - A following good 0x29 → `[7:0]`=29, pressed set.
  - Separately, a 2-cycle low glitch on `ps2_clk` (FILT_LEN=4) produces no bit event.
- **Timeout:** send 5 bits, then hold the clock high for TIMEOUT cycles → one `byte_err`. A following full 0x16 frame decodes to `[7:0]`=16.
- **Pause and controller responses:**
  - E1 14 77 E1 F0 14 F0 77 → no `ps2_key` change. The next 0x1E emits with pressed=1, ext=0.
  - Byte AA in IDLE → no emission.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard deserializer and prefix folder producing {toggle, pressed, extended, code} events.
// Event lands one cycle after the stop-bit sample; the keyboard cannot be stalled, so there is no backpressure.
module ps2_key_encoder #(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        byte_valid,
  output logic        byte_err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          bit_evt;

  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;

  logic          frame_done, frame_ok, timeout_hit, err_now;
  logic [7:0]    rx_byte;

  logic [2:0]    state, nxt_state;
  logic [2:0]    skip_cnt, nxt_skip;
  logic          emit, is_resp;

  // Idle-high reset values keep the synchronizers from faking a falling edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      bit_evt  <= 1'b0;
    end else begin
      bit_evt <= 1'b0;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
        bit_evt  <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // shreg holds start..parity once ten bits are in; the stop bit is checked live.
  assign frame_done  = bit_evt && (bit_cnt == 4'd10);
  assign frame_ok    = frame_done && !shreg[0] && (^shreg[9:1]) && data_sync;
  assign timeout_hit = !bit_evt && (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT));
  assign err_now     = (frame_done && !frame_ok) || timeout_hit;
  assign rx_byte     = shreg[8:1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      shreg      <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= frame_ok;
      byte_err   <= err_now;
      if (bit_evt) begin
        to_cnt <= '0;
        if (frame_done) begin
          bit_cnt <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {data_sync, shreg[9:1]};
        end
      end else begin
        if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
        if (timeout_hit) bit_cnt <= 4'd0;
      end
    end
  end

  always_comb begin
    is_resp = 1'b0;
    case (rx_byte)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_resp = 1'b1;
      default: is_resp = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_skip  = skip_cnt;
    emit      = 1'b0;
    if (err_now) begin
      nxt_state = ST_IDLE;
      nxt_skip  = 3'd0;
    end else if (frame_ok) begin
      if (state == ST_SKIP) begin
        if (skip_cnt != 3'd0) nxt_skip = skip_cnt - 3'd1;
        if (skip_cnt <= 3'd1) nxt_state = ST_IDLE;
      end else if (rx_byte == 8'hE1) begin
        nxt_state = ST_SKIP;
        nxt_skip  = 3'd7;
      end else if (rx_byte == 8'hE0) begin
        nxt_state = (state == ST_BRK || state == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
      end else if (rx_byte == 8'hF0) begin
        nxt_state = (state == ST_EXT || state == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else if (state == ST_IDLE && is_resp) begin
        nxt_state = ST_IDLE;
      end else begin
        emit      = 1'b1;
        nxt_state = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
      ps2_key  <= 11'h000;
    end else begin
      state    <= nxt_state;
      skip_cnt <= nxt_skip;
      if (emit) begin
        ps2_key <= {~ps2_key[10],
                    !(state == ST_BRK || state == ST_EXT_BRK),
                    (state == ST_EXT || state == ST_EXT_BRK),
                    rx_byte};
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed plus randomized frames against a flag-based key model.
module tb_ps2_key_encoder;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        byte_valid;
  logic        byte_err;

  ps2_key_encoder #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .byte_valid(byte_valid), .byte_err(byte_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int vld_seen = 0, err_seen = 0, tog_seen = 0, incoh = 0, both = 0;
  logic [10:0] prev_key = 11'h000;

  always @(negedge clk) begin
    if (byte_valid) vld_seen++;
    if (byte_err) err_seen++;
    if (byte_valid && byte_err) both++;
    if (!reset) begin
      if (ps2_key[10] !== prev_key[10]) tog_seen++;
      else if (ps2_key[9:0] !== prev_key[9:0]) incoh++;
    end
    prev_key = ps2_key;
  end

  // Reference model: pending-prefix flags plus a count of bytes still to swallow.
  logic [10:0] m_key = 11'h000;
  bit m_ext = 0, m_brk = 0;
  int m_skip = 0;
  int exp_vld = 0, exp_err = 0, exp_tog = 0;
  logic [7:0] resp [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  function automatic bit is_resp(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (resp[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_err();
    exp_err++;
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      model_err();
      return;
    end
    exp_vld++;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && !m_brk && is_resp(b)) begin
      // controller response, dropped
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      exp_tog++;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "/key"}, 32'(ps2_key), 32'(m_key));
    check({tag, "/vld"}, vld_seen, exp_vld);
    check({tag, "/err"}, err_seen, exp_err);
    check({tag, "/tog"}, tog_seen, exp_tog);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(8);
    ps2_clk = 1'b1;
    wait_cyc(8);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send(input logic [7:0] b, input bit bad);
    send_bits(frame_bits(b, bad), 11);
    model_byte(b, !bad);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] key_before;
    logic [7:0]  pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0]  b;

    reset = 1'b1;
    wait_cyc(4);
    check("reset/key", 32'(ps2_key), 32'h000);
    check("reset/vld", 32'(byte_valid), 32'h0);
    check("reset/err", 32'(byte_err), 32'h0);
    reset = 1'b0;
    wait_cyc(2);

    send(8'h1C, 0);
    check_frame("press");
    check("press_lit", 32'(ps2_key), 32'h61C);

    send(8'hF0, 0);
    check_frame("rel_prefix");
    send(8'h1C, 0);
    check_frame("release");
    check("release_lit", 32'(ps2_key), 32'h01C);

    send(8'hE0, 0);
    send(8'h75, 0);
    check_frame("ext_press");
    check("ext_press_lit", 32'(ps2_key), 32'h775);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 0);
    check_frame("ext_release");
    check("ext_release_lit", 32'(ps2_key), 32'h175);

    send(8'h1C, 1);
    check_frame("parity_err");
    check("parity_err_lit", 32'(ps2_key), 32'h175);
    send(8'h29, 0);
    check_frame("after_parity");
    check("after_parity_lit", 32'(ps2_key), 32'h629);

    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check_frame("glitch");
    send(8'h33, 0);
    check_frame("after_glitch");

    send_bits(frame_bits(8'h16, 0), 5);
    wait_cyc(TIMEOUT + 40);
    model_err();
    check_frame("timeout");
    send(8'h16, 0);
    check_frame("after_timeout");
    check("after_timeout_lit", 32'(ps2_key[9:0]), 32'h216);

    key_before = m_key;
    for (int i = 0; i < 8; i++) send(pause_seq[i], 0);
    check_frame("pause");
    check("pause_hold", 32'(ps2_key), 32'(key_before));
    send(8'h1E, 0);
    check_frame("after_pause");
    check("after_pause_lit", 32'(ps2_key[9:0]), 32'h21E);

    key_before = m_key;
    send(8'hAA, 0);
    check_frame("resp_drop");
    check("resp_hold", 32'(ps2_key), 32'(key_before));

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        4:       send(8'hE0, 0);
        5:       send(8'hF0, 0);
        6:       send(8'hE1, 0);
        7:       send(resp[$urandom_range(0, 7)], 0);
        8:       begin b = 8'($urandom); send(b, 1); end
        default: begin b = 8'($urandom); send(b, 0); end
      endcase
      check_frame("random");
    end

    send_bits(frame_bits(8'h5A, 0), 5);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset/key", 32'(ps2_key), 32'h000);
    reset = 1'b0;
    m_key = 11'h000; m_ext = 0; m_brk = 0; m_skip = 0;
    wait_cyc(2);
    send(8'h1C, 0);
    check_frame("after_midreset");
    check("after_midreset_lit", 32'(ps2_key), 32'h61C);

    wait_cyc(TIMEOUT + 20);
    check_frame("idle_no_timeout");
    check("incoherent_key_change", incoh, 0);
    check("valid_err_overlap", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
